// File: rtl/core0_pkg.sv
// Shared core0 definitions: redirect kinds and step normalisation.
package core0_pkg;

  typedef enum logic [2:0] {
    SEQ,
    BRANCH,
    JUMP_IMM,
    JUMP_STACK,
    RET
  } redirect_e;

  localparam logic [1:0] STEP_ONE = 2'd1;

  // Only a step of 2 is honoured; 0 and 3 collapse to one word.
  function automatic logic [1:0] norm_step(input logic [1:0] s);
    return (s == 2'd2) ? 2'd2 : STEP_ONE;
  endfunction

endpackage

// File: rtl/return_stack.sv
// Return-address LIFO for core0 fetch.
// PC_STACK_GUARD_EN: drop overflow pushes, refuse empty pops, flag error.
module return_stack
  import core0_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int CALL_DEPTH = 16,
  localparam int AW = $clog2(CALL_DEPTH),
  localparam int DW = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WORD_WIDTH-1:0] push_data,
  output logic [WORD_WIDTH-1:0] top_data,
  output logic [DW-1:0]         depth,
  output logic                  pop_valid,
  output logic                  error
);

  logic [WORD_WIDTH-1:0] mem_q [CALL_DEPTH];
  logic [DW-1:0] depth_q, depth_d;
  logic          error_q, error_d;
  logic [AW-1:0] wr_idx, rd_idx;
  logic          do_push, do_pop;

  assign wr_idx   = depth_q[AW-1:0];
  assign rd_idx   = wr_idx - AW'(1);
  assign top_data = mem_q[rd_idx];

`ifdef PC_STACK_GUARD_EN
  logic full, empty;
  assign full      = (depth_q == DW'(CALL_DEPTH));
  assign empty     = (depth_q == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign pop_valid = ~empty;
  assign error_d   = error_q | (push & full) | (pop & empty);
`else
  assign do_push   = push;
  assign do_pop    = pop;
  assign pop_valid = 1'b1;
  assign error_d   = 1'b0;
`endif

  always_comb begin
    depth_d = depth_q;
    if (do_push)
      depth_d = depth_q + DW'(1);
    else if (do_pop)
      depth_d = depth_q - DW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      depth_q <= '0;
      error_q <= 1'b0;
    end else begin
      depth_q <= depth_d;
      error_q <= error_d;
    end
  end

  // Contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (do_push)
      mem_q[wr_idx] <= push_data;
  end

  assign depth = depth_q;
  assign error = error_q;

endmodule

// File: rtl/program_counter.sv
// Fetch PC with branch/jump/call/return selection for core0.
// PC_STACK_GUARD_EN enables return-stack overflow/underflow guarding.
module program_counter
  import core0_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int CALL_DEPTH = 16,
  parameter logic [WORD_WIDTH-1:0] RESET_VECTOR = '0,
  localparam int DW = $clog2(CALL_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  advance,
  input  logic [1:0]            step,
  input  logic                  branch,
  input  logic                  jump_immediate,
  input  logic                  jump_stack,
  input  logic                  is_call,
  input  logic                  ret,
  input  logic [WORD_WIDTH-1:0] immediate,
  input  logic [WORD_WIDTH-1:0] top,
  output logic [WORD_WIDTH-1:0] pc,
  output logic                  flush,
  output logic [DW-1:0]         call_depth,
  output logic                  stack_error
);

  logic [WORD_WIDTH-1:0] pc_q, pc_d;
  logic                  flush_q, flush_d;
  logic [WORD_WIDTH-1:0] seq_pc, br_pc, ret_pc;
  logic                  pop_valid, push, pop;
  redirect_e             kind;

  assign seq_pc = pc_q + WORD_WIDTH'(norm_step(step));
  assign br_pc  = pc_q + immediate;

  always_comb begin
    kind = SEQ;
    if (ret)
      kind = pop_valid ? RET : SEQ;
    else if (jump_stack)
      kind = JUMP_STACK;
    else if (jump_immediate)
      kind = JUMP_IMM;
    else if (branch)
      kind = BRANCH;
  end

  assign push = advance & is_call &
                ((kind == JUMP_STACK) | (kind == JUMP_IMM));
  assign pop  = advance & ret;

  always_comb begin
    pc_d    = pc_q;
    flush_d = 1'b0;
    if (advance) begin
      flush_d = (kind != SEQ);
      unique case (kind)
        RET:        pc_d = ret_pc;
        JUMP_STACK: pc_d = top;
        JUMP_IMM:   pc_d = immediate;
        BRANCH:     pc_d = br_pc;
        default:    pc_d = seq_pc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_VECTOR;
      flush_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      flush_q <= flush_d;
    end
  end

  return_stack #(
    .WORD_WIDTH(WORD_WIDTH),
    .CALL_DEPTH(CALL_DEPTH)
  ) u_rs (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .push_data (seq_pc),
    .top_data  (ret_pc),
    .depth     (call_depth),
    .pop_valid (pop_valid),
    .error     (stack_error)
  );

  assign pc    = pc_q;
  assign flush = flush_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter.
module tb_program_counter;

  logic        clk;
  logic        reset_n;
  logic        advance;
  logic [1:0]  step;
  logic        branch;
  logic        jump_immediate;
  logic        jump_stack;
  logic        is_call;
  logic        ret;
  logic [31:0] immediate;
  logic [31:0] top;
  logic [31:0] pc;
  logic        flush;
  logic [4:0]  call_depth;
  logic        stack_error;

  int checks;
  int errors;

  program_counter dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .advance        (advance),
    .step           (step),
    .branch         (branch),
    .jump_immediate (jump_immediate),
    .jump_stack     (jump_stack),
    .is_call        (is_call),
    .ret            (ret),
    .immediate      (immediate),
    .top            (top),
    .pc             (pc),
    .flush          (flush),
    .call_depth     (call_depth),
    .stack_error    (stack_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic go(input logic a, input logic [1:0] s,
                    input logic br, input logic ji,
                    input logic js, input logic c,
                    input logic r, input logic [31:0] imm,
                    input logic [31:0] tp);
    advance = a; step = s; branch = br;
    jump_immediate = ji; jump_stack = js;
    is_call = c; ret = r; immediate = imm; top = tp;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    advance = 0; step = 1; branch = 0;
    jump_immediate = 0; jump_stack = 0;
    is_call = 0; ret = 0; immediate = 0; top = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pc !== 32'h0) begin
      errors++; $display("FAIL reset_pc got %h want %h", pc, 32'h0);
    end
    checks++;
    if (flush !== 1'b0 || call_depth !== 5'd0 || stack_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got f=%b d=%0d e=%b want 0 0 0",
               flush, call_depth, stack_error);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [6];
    logic [1:0]  steps [6];
    steps  = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd3, 2'd2};
    exp_pc = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd7};
    for (int i = 0; i < 6; i++) begin
      go(1, steps[i], 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (pc !== exp_pc[i] || flush !== 1'b0) begin
        errors++;
        $display("FAIL seq_%0d got pc=%h f=%b want pc=%h f=0",
                 i, pc, flush, exp_pc[i]);
      end
    end
  endtask

  task automatic test_branch();
    go(1, 1, 0, 1, 0, 0, 0, 32'h10, 0);
    checks++;
    if (pc !== 32'h10 || flush !== 1'b1) begin
      errors++; $display("FAIL jump_to_10 got pc=%h f=%b want 10 1", pc, flush);
    end
    go(1, 1, 1, 0, 0, 0, 0, 32'hFFFF_FFFC, 0);
    checks++;
    if (pc !== 32'h0C || flush !== 1'b1) begin
      errors++; $display("FAIL branch_back got pc=%h f=%b want c 1", pc, flush);
    end
    go(0, 1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (pc !== 32'h0C || flush !== 1'b0) begin
      errors++; $display("FAIL branch_after got pc=%h f=%b want c 0", pc, flush);
    end
  endtask

  task automatic test_call_ret();
    go(1, 1, 0, 1, 0, 0, 0, 32'h20, 0);
    go(1, 2, 0, 1, 0, 1, 0, 32'h100, 0);
    checks++;
    if (pc !== 32'h100 || call_depth !== 5'd1 || flush !== 1'b1) begin
      errors++;
      $display("FAIL call got pc=%h d=%0d f=%b want 100 1 1",
               pc, call_depth, flush);
    end
    go(1, 1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (pc !== 32'h101 || flush !== 1'b0) begin
      errors++; $display("FAIL in_callee got pc=%h f=%b want 101 0", pc, flush);
    end
    go(1, 1, 0, 0, 0, 0, 1, 0, 0);
    checks++;
    if (pc !== 32'h22 || call_depth !== 5'd0 || flush !== 1'b1) begin
      errors++;
      $display("FAIL ret got pc=%h d=%0d f=%b want 22 0 1",
               pc, call_depth, flush);
    end
  endtask

  task automatic test_priority();
    go(1, 1, 0, 1, 0, 1, 0, 32'h200, 0);
    // ret beats jump_stack, branch and the call qualifier
    go(1, 1, 1, 1, 1, 1, 1, 32'h4, 32'h300);
    checks++;
    if (pc !== 32'h23 || call_depth !== 5'd0 || flush !== 1'b1) begin
      errors++;
      $display("FAIL prio_ret got pc=%h d=%0d f=%b want 23 0 1",
               pc, call_depth, flush);
    end
    go(0, 1, 1, 1, 1, 1, 1, 32'h4, 32'h300);
    checks++;
    if (pc !== 32'h23 || call_depth !== 5'd0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL prio_hold got pc=%h d=%0d f=%b want 23 0 0",
               pc, call_depth, flush);
    end
    go(1, 1, 1, 1, 1, 0, 0, 32'h40, 32'h300);
    checks++;
    if (pc !== 32'h300 || flush !== 1'b1) begin
      errors++; $display("FAIL prio_js got pc=%h f=%b want 300 1", pc, flush);
    end
    go(1, 1, 1, 1, 0, 0, 0, 32'h40, 32'h300);
    checks++;
    if (pc !== 32'h40) begin
      errors++; $display("FAIL prio_ji got pc=%h want 40", pc);
    end
    go(0, 1, 1, 1, 0, 0, 0, 32'h80, 32'h300);
    checks++;
    if (pc !== 32'h40 || flush !== 1'b0) begin
      errors++; $display("FAIL prio_hold2 got pc=%h f=%b want 40 0", pc, flush);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r [17];
    logic [31:0] exp_pc;
    logic [4:0]  exp_d;
    logic        exp_f;
    logic        exp_e;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      r[i] = (i == 0) ? 32'h1 : 32'h1000 + 32'(i - 1) * 32'h10 + 32'h1;
      go(1, 1, 0, 1, 0, 1, 0, 32'h1000 + 32'(i) * 32'h10, 0);
`ifdef PC_STACK_GUARD_EN
      exp_d = (i < 16) ? 5'(i + 1) : 5'd16;
`else
      exp_d = 5'(i + 1);
`endif
      checks++;
      if (pc !== 32'h1000 + 32'(i) * 32'h10 || call_depth !== exp_d) begin
        errors++;
        $display("FAIL call_%0d got pc=%h d=%0d want d=%0d",
                 i, pc, call_depth, exp_d);
      end
    end
`ifdef PC_STACK_GUARD_EN
    exp_e = 1'b1;
`else
    exp_e = 1'b0;
`endif
    checks++;
    if (stack_error !== exp_e) begin
      errors++;
      $display("FAIL overflow_err got %b want %b", stack_error, exp_e);
    end
    for (int j = 0; j < 17; j++) begin
`ifdef PC_STACK_GUARD_EN
      exp_pc = (j < 16) ? r[15 - j] : r[0] + 32'h1;
      exp_d  = (j < 16) ? 5'(15 - j) : 5'd0;
      exp_f  = (j < 16);
`else
      exp_pc = (j == 0 || j == 16) ? r[16] : r[16 - j];
      exp_d  = 5'(16 - j);
      exp_f  = 1'b1;
`endif
      go(1, 1, 0, 0, 0, 0, 1, 0, 0);
      checks++;
      if (pc !== exp_pc || call_depth !== exp_d || flush !== exp_f) begin
        errors++;
        $display("FAIL ret_%0d got pc=%h d=%0d f=%b want pc=%h d=%0d f=%b",
                 j, pc, call_depth, flush, exp_pc, exp_d, exp_f);
      end
    end
    checks++;
    if (stack_error !== exp_e) begin
      errors++;
      $display("FAIL final_err got %b want %b", stack_error, exp_e);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++)
      go(1, 1, 0, 1, 0, 1, 0, 32'h500 + 32'(i) * 32'h8, 0);
    checks++;
    if (call_depth !== 5'd3 || flush !== 1'b1 || pc !== 32'h510) begin
      errors++;
      $display("FAIL pre_async got pc=%h d=%0d f=%b want 510 3 1",
               pc, call_depth, flush);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h0 || call_depth !== 5'd0 ||
        flush !== 1'b0 || stack_error !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got pc=%h d=%0d f=%b e=%b want 0 0 0 0",
               pc, call_depth, flush, stack_error);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    go(1, 1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (pc !== 32'h1) begin
      errors++; $display("FAIL post_async got pc=%h want 1", pc);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_call_ret();
    test_priority();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
